// File: rtl/act_pack_writer.sv
// ============================================================================
// act_pack_writer : packs 1-bit activations LSB-first into SRAM words
// Rev 1.0
// ============================================================================
`default_nettype none

module act_pack_writer #(
  parameter int PACK_W = 16,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_bits,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PACK_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int IDX_W = (PACK_W > 1) ? $clog2(PACK_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PACK  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [CNT_W-1:0]    rcvd_q, rcvd_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [PACK_W-1:0]   shreg_q, shreg_d;
  logic                hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
  logic [PACK_W-1:0]   hold_data_q, hold_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                overflow_q, overflow_d;

  logic                w_accept;
  logic                w_last;
  logic [PACK_W-1:0]   w_word;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    num_d        = num_q;
    rcvd_d       = rcvd_q;
    bit_idx_d    = bit_idx_q;
    word_idx_d   = word_idx_q;
    shreg_d      = shreg_q;
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    overflow_d   = overflow_q;
    w_last       = 1'b0;
    w_word       = shreg_q;

    w_accept = hold_valid_q && wr_ready;
    if (w_accept) begin
      hold_valid_d = 1'b0;
    end

    // A start in any state restarts the layer and discards a pending word.
    if (start) begin
      base_d       = base_addr;
      num_d        = num_bits;
      rcvd_d       = '0;
      bit_idx_d    = '0;
      word_idx_d   = '0;
      shreg_d      = '0;
      overflow_d   = 1'b0;
      hold_valid_d = 1'b0;
      state_d      = (num_bits == '0) ? S_DONE : S_PACK;
    end else begin
      case (state_q)
        S_PACK: begin
          if (bit_valid) begin
            w_word[bit_idx_q] = bit_in;
            w_last            = (rcvd_q == num_q - CNT_W'(1));
            rcvd_d            = rcvd_q + CNT_W'(1);
            if ((bit_idx_q == LAST_IDX) || w_last) begin
              // Drop on collision, but still advance so later addresses stay right.
              if (!hold_valid_q || w_accept) begin
                hold_valid_d = 1'b1;
                hold_addr_d  = base_q + word_idx_q;
                hold_data_d  = w_word;
              end else begin
                overflow_d = 1'b1;
              end
              word_idx_d = word_idx_q + ADDR_W'(1);
              bit_idx_d  = '0;
              shreg_d    = '0;
            end else begin
              shreg_d   = w_word;
              bit_idx_d = bit_idx_q + IDX_W'(1);
            end
            if (w_last) begin
              state_d = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!hold_valid_q) begin
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_PACK) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      num_q        <= '0;
      rcvd_q       <= '0;
      bit_idx_q    <= '0;
      word_idx_q   <= '0;
      shreg_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      num_q        <= num_d;
      rcvd_q       <= rcvd_d;
      bit_idx_q    <= bit_idx_d;
      word_idx_q   <= word_idx_d;
      shreg_q      <= shreg_d;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign wr_en    = hold_valid_q;
  assign wr_addr  = hold_addr_q;
  assign wr_data  = hold_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire
